// File: rtl/pcore_pkg.sv
// Shared pcore interface definitions for the instruction alignment front end.
//   HW_DEPTH           : halfword queue depth
//   OPC_UNCOMP         : opcode[1:0] marking a 32-bit (uncompressed) instruction
//   type_align_state_e : fetch FSM state (idle / request outstanding / stale response)
package pcore_pkg;

    localparam int unsigned HW_DEPTH   = 3;
    localparam logic [1:0]  OPC_UNCOMP = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop
    } type_align_state_e;

    // Anything but 2'b11 in the low bits is a 16-bit instruction, including all-zero.
    function automatic logic is_comp(input logic [15:0] hw);
        return hw[1:0] != OPC_UNCOMP;
    endfunction

endpackage

// File: rtl/inst_hw_queue.sv
// In-order halfword queue, HW_DEPTH entries, entry 0 is the head.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : empty the queue (wins over push/pop)
//   push_cnt_i   : halfwords appended this cycle (0/1/2)
//   push_data_i  : [15:0] appended first, [31:16] second
//   pop_cnt_i    : halfwords removed from the head this cycle (0/1/2)
//   count_o      : occupancy
//   head_o/next_o: entries 0 and 1
module inst_hw_queue
    import pcore_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [1:0]  push_cnt_i,
    input  logic [31:0] push_data_i,
    input  logic [1:0]  pop_cnt_i,
    output logic [1:0]  count_o,
    output logic [15:0] head_o,
    output logic [15:0] next_o
);

    logic [15:0] hw_q [HW_DEPTH];
    logic [15:0] hw_d [HW_DEPTH];
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  base;

    always_comb begin
        // Pop first (shift toward the head), then append behind what remains.
        base  = cnt_q - pop_cnt_i;
        cnt_d = base + push_cnt_i;
        case (pop_cnt_i)
            2'd1: begin
                hw_d[0] = hw_q[1];
                hw_d[1] = hw_q[2];
                hw_d[2] = 16'h0;
            end
            2'd2: begin
                hw_d[0] = hw_q[2];
                hw_d[1] = 16'h0;
                hw_d[2] = 16'h0;
            end
            default: hw_d = hw_q;
        endcase
        for (int i = 0; i < HW_DEPTH; i++) begin
            if (push_cnt_i != 2'd0 && base == 2'(i)) begin
                hw_d[i] = push_data_i[15:0];
            end
            if (push_cnt_i == 2'd2 && (base + 2'd1) == 2'(i)) begin
                hw_d[i] = push_data_i[31:16];
            end
        end
        if (flush_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            hw_q  <= '{default: 16'h0};
        end else begin
            cnt_q <= cnt_d;
            hw_q  <= hw_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = hw_q[0];
    assign next_o  = hw_q[1];

endmodule

// File: rtl/inst_align_buf.sv
// Instruction alignment buffer: fetches 32-bit words and presents 16/32-bit
// instructions at halfword-aligned PCs.
//   clk, rst                       : clock, synchronous active-high reset
//   imem_req_o/addr_o              : one-cycle fetch request, word-aligned address
//   imem_ack_i/rdata_i             : fetch response (one outstanding at most)
//   redirect_i/redirect_pc_i       : flush and restart at a halfword-aligned target
//   inst_valid_o/ready_i           : downstream handshake
//   inst_o/inst_pc_o/inst_is_comp_o: head instruction, its PC, compressed flag
module inst_align_buf
    import pcore_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_is_comp_o
);

    type_align_state_e state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_lo_q, skip_lo_d;

    logic [1:0]  cnt;
    logic [15:0] head_hw, next_hw;
    logic        head_comp, ack_take;
    logic [1:0]  push_cnt, pop_cnt;
    logic [31:0] push_data;

    inst_hw_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_i),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_cnt_i   (pop_cnt),
        .count_o     (cnt),
        .head_o      (head_hw),
        .next_o      (next_hw)
    );

    always_comb begin
        head_comp      = is_comp(head_hw);
        inst_valid_o   = ~rst & ~redirect_i & ((cnt >= 2'd1 & head_comp) | (cnt >= 2'd2));
        inst_is_comp_o = head_comp;
        inst_pc_o      = pc_q;
        inst_o         = rst ? 32'h0 : (head_comp ? {16'h0, head_hw} : {next_hw, head_hw});

        // Requesting only at cnt<=1 guarantees room for a full word on return.
        imem_req_o  = ~rst & ~redirect_i & (state_q == StIdle) & (cnt <= 2'd1);
        imem_addr_o = fetch_addr_q;

        ack_take  = ~redirect_i & (state_q == StWait) & imem_ack_i;
        push_cnt  = ack_take ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
        push_data = skip_lo_q ? {16'h0, imem_rdata_i[31:16]} : imem_rdata_i;
        pop_cnt   = (inst_valid_o & inst_ready_i) ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        skip_lo_d    = skip_lo_q;

        if (redirect_i) begin
            pc_d         = {redirect_pc_i[31:1], 1'b0};
            fetch_addr_d = {redirect_pc_i[31:2], 2'b00};
            skip_lo_d    = redirect_pc_i[1];
            // An ack arriving with the redirect already retires the outstanding
            // request, so there is nothing left to drop.
            case (state_q)
                StIdle:  state_d = StIdle;
                default: state_d = imem_ack_i ? StIdle : StDrop;
            endcase
        end else begin
            pc_d = pc_q + {29'h0, pop_cnt, 1'b0};
            case (state_q)
                StIdle: begin
                    if (imem_req_o) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_ack_i) begin
                        state_d      = StIdle;
                        fetch_addr_d = fetch_addr_q + 32'd4;
                        skip_lo_d    = 1'b0;
                    end
                end
                StDrop: begin
                    if (imem_ack_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            fetch_addr_q <= RESET_PC & ~32'h3;
            pc_q         <= RESET_PC;
            skip_lo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            skip_lo_q    <= skip_lo_d;
        end
    end

endmodule

// File: tb/tb_inst_align_buf.sv
module tb_inst_align_buf;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_is_comp_o;

    always #5 clk = ~clk;

    inst_align_buf #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_is_comp_o (inst_is_comp_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: word array indexed by addr[9:2], fixed ack latency.
    logic [31:0] mem [0:255];
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;

    logic [31:0] got_inst [$];
    logic [31:0] got_pc [$];
    logic        got_comp [$];
    logic [31:0] req_addr [$];

    typedef struct packed {
        logic        redir;
        logic [31:0] target;
        logic [31:0] w0;     // word at the fetch base
        logic [31:0] w1;     // word at fetch base + 4
        logic [3:0]  lat;
        logic [31:0] i0; logic [31:0] p0; logic c0;
        logic [31:0] i1; logic [31:0] p1; logic c1;
        logic [31:0] i2; logic [31:0] p2; logic c2;
        logic [31:0] r0; logic [31:0] r1;  // first two fetch addresses
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample 1ns later.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'hdead_beef;
        if (pend) begin
            if (pend_wait == 0) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem[pend_addr[9:2]];
                pend         = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        rst           = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
        #1;
        if (!r && inst_valid_o && rdy) begin
            got_inst.push_back(inst_o);
            got_pc.push_back(inst_pc_o);
            got_comp.push_back(inst_is_comp_o);
        end
        if (imem_req_o) begin
            check("single_outstanding", {31'h0, pend}, 32'h0);
            pend      = 1'b1;
            pend_addr = imem_addr_o;
            pend_wait = lat - 1;
            req_addr.push_back(imem_addr_o);
        end
        if (r) pend = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        got_inst.delete();
        got_pc.delete();
        got_comp.delete();
        req_addr.delete();
        pend = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic run_until(input int n, input int max_cyc);
        for (int c = 0; c < max_cyc && got_inst.size() < n; c++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("accept_count", got_inst.size(), n);
    endtask

    initial begin
        logic [31:0] base;
        logic [7:0]  idx;

        // Hand-computed vectors. The split case uses halfwords 0x0001, 0x0013,
        // 0x0000 in fetch order, i.e. words 0x0013_0001 then 0x0000_0000.
        vecs[0] = '{1'b0, 32'h0, 32'h0001_4501, 32'h0, 4'd1,
                    32'h4501, 32'h0, 1'b1, 32'h0001, 32'h2, 1'b1, 32'h0, 32'h4, 1'b1,
                    32'h0, 32'h4};
        vecs[1] = '{1'b0, 32'h0, 32'h0013_0001, 32'h0, 4'd1,
                    32'h0001, 32'h0, 1'b1, 32'h0000_0013, 32'h2, 1'b0, 32'h0, 32'h6, 1'b1,
                    32'h0, 32'h4};
        vecs[2] = '{1'b1, 32'h102, 32'h4505_4501, 32'h0, 4'd1,
                    32'h4505, 32'h102, 1'b1, 32'h0, 32'h104, 1'b1, 32'h0, 32'h106, 1'b1,
                    32'h100, 32'h104};
        vecs[3] = '{1'b1, 32'h200, 32'h1234_5677, 32'h0, 4'd1,
                    32'h1234_5677, 32'h200, 1'b0, 32'h0, 32'h204, 1'b1, 32'h0, 32'h206, 1'b1,
                    32'h200, 32'h204};
        vecs[4] = '{1'b1, 32'h42, 32'h5677_0001, 32'h0011_1234, 4'd3,
                    32'h1234_5677, 32'h42, 1'b0, 32'h0011, 32'h46, 1'b1, 32'h0, 32'h48, 1'b1,
                    32'h40, 32'h44};

        // Reset state.
        clear_mem();
        lat = 1;
        do_reset();
        check("rst_req", {31'h0, imem_req_o}, 32'h0);
        check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_pc", inst_pc_o, RESET_PC);
        check("rst_req_addr", imem_addr_o, RESET_PC & ~32'h3);
        check("rst_first_req", {31'h0, imem_req_o}, 32'h1);

        for (int v = 0; v < 5; v++) begin
            clear_mem();
            lat = int'(vecs[v].lat);
            do_reset();
            base = vecs[v].redir ? vecs[v].target : RESET_PC;
            idx  = base[9:2];
            mem[idx]        = vecs[v].w0;
            mem[idx + 8'd1] = vecs[v].w1;
            if (vecs[v].redir) step(1'b0, 1'b1, vecs[v].target, 1'b1);
            run_until(3, 60);
            if (got_inst.size() >= 3) begin
                check($sformatf("v%0d_inst0", v), got_inst[0], vecs[v].i0);
                check($sformatf("v%0d_pc0", v), got_pc[0], vecs[v].p0);
                check($sformatf("v%0d_comp0", v), {31'h0, got_comp[0]}, {31'h0, vecs[v].c0});
                check($sformatf("v%0d_inst1", v), got_inst[1], vecs[v].i1);
                check($sformatf("v%0d_pc1", v), got_pc[1], vecs[v].p1);
                check($sformatf("v%0d_comp1", v), {31'h0, got_comp[1]}, {31'h0, vecs[v].c1});
                check($sformatf("v%0d_inst2", v), got_inst[2], vecs[v].i2);
                check($sformatf("v%0d_pc2", v), got_pc[2], vecs[v].p2);
                check($sformatf("v%0d_comp2", v), {31'h0, got_comp[2]}, {31'h0, vecs[v].c2});
            end
            check($sformatf("v%0d_nreq", v), {31'h0, req_addr.size() >= 2}, 32'h1);
            if (req_addr.size() >= 2) begin
                check($sformatf("v%0d_req0", v), req_addr[0], vecs[v].r0);
                check($sformatf("v%0d_req1", v), req_addr[1], vecs[v].r1);
            end
        end

        // Redirect while a fetch is outstanding; the stale ack must be dropped.
        clear_mem();
        mem[0]    = 32'h4501_4501;
        mem[8'hC0] = 32'h0009_0005;
        lat = 2;
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h300, 1'b1);
        check("drop_redir_valid", {31'h0, inst_valid_o}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drop_stale_ack", {31'h0, imem_ack_i}, 32'h1);
        check("drop_no_req", {31'h0, imem_req_o}, 32'h0);
        check("drop_valid", {31'h0, inst_valid_o}, 32'h0);
        run_until(1, 30);
        if (got_inst.size() >= 1) begin
            check("drop_inst", got_inst[0], 32'h0005);
            check("drop_pc", got_pc[0], 32'h300);
        end
        if (req_addr.size() >= 2) check("drop_refetch", req_addr[1], 32'h300);
        else check("drop_refetch_cnt", req_addr.size(), 2);

        // Backpressure with a full queue.
        clear_mem();
        mem[0] = 32'h4505_4501;
        mem[1] = 32'h4511_4509;
        lat = 1;
        do_reset();
        run_until(1, 20);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("stall%0d_req", c), {31'h0, imem_req_o}, 32'h0);
            check($sformatf("stall%0d_valid", c), {31'h0, inst_valid_o}, 32'h1);
            check($sformatf("stall%0d_inst", c), inst_o, 32'h4505);
            check($sformatf("stall%0d_pc", c), inst_pc_o, 32'h2);
        end
        run_until(4, 20);
        if (got_inst.size() >= 4) begin
            check("stall_inst1", got_inst[1], 32'h4505);
            check("stall_pc1", got_pc[1], 32'h2);
            check("stall_inst2", got_inst[2], 32'h4509);
            check("stall_pc2", got_pc[2], 32'h4);
            check("stall_inst3", got_inst[3], 32'h4511);
            check("stall_pc3", got_pc[3], 32'h6);
        end

        // Reset in WAIT with the ack in the same cycle.
        clear_mem();
        mem[0] = 32'h4505_4501;
        lat = 1;
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("rstwait_ack", {31'h0, imem_ack_i}, 32'h1);
        check("rstwait_req", {31'h0, imem_req_o}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rstwait_valid", {31'h0, inst_valid_o}, 32'h0);
        check("rstwait_inst", inst_o, 32'h0);
        check("rstwait_pc", inst_pc_o, RESET_PC);
        got_inst.delete();
        got_pc.delete();
        got_comp.delete();
        run_until(2, 20);
        if (got_inst.size() >= 2) begin
            check("rstwait_inst0", got_inst[0], 32'h4501);
            check("rstwait_pc0", got_pc[0], 32'h0);
            check("rstwait_inst1", got_inst[1], 32'h4505);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
